// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the 2x2/stride-2 max-pool stage.
// MAXPOOL_RELU_EN selects signed comparison (and a ReLU clamp in the top).
package maxpool_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_W = 8;
    localparam int MAX_W          = 64;

    // Operands arrive zero-extended in MAX_W bits; left-aligning the w-bit
    // value puts its sign bit at the MSB, so one compare serves either signedness.
    function automatic logic [MAX_W-1:0] max_val(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int unsigned      w);
        logic [MAX_W-1:0] a_l;
        logic [MAX_W-1:0] b_l;
        a_l = a << (MAX_W - w);
        b_l = b << (MAX_W - w);
`ifdef MAXPOOL_RELU_EN
        return ($signed(a_l) >= $signed(b_l)) ? a : b;
`else
        return (a_l >= b_l) ? a : b;
`endif
    endfunction

endpackage

// File: rtl/maxpool_linebuf.sv
// Line buffer holding the horizontal pair maxima of the previous even row.
// One synchronous write port, one combinational read port.
module maxpool_linebuf
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
)
(
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: no reset on the array -- every entry is written on an even row
    // before the following odd row reads it, so a reset would only cost area.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/conv_maxpool.sv
// 2x2, stride-2 max pooling over a raster-order feature-map stream.
// Define MAXPOOL_RELU_EN for signed pixels with a fused ReLU clamp.
module conv_maxpool
    import maxpool_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int CW       = $clog2(IMG_W);
    localparam int RW       = $clog2(IMG_H);
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] pair_q;
    logic [DATA_W-1:0] pm;
    logic [DATA_W-1:0] lb_rdata;
    logic [DATA_W-1:0] pooled;
    logic [LB_AW-1:0]  lb_addr;
    logic              accept;
    logic              last_pix;
    logic              lb_we;
    logic              emit;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default first, so every path assigns state_next and no latch forms.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = RUN;
            RUN:     if (last_pix) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == RUN);
        busy     = (state == RUN);
    end

    assign accept   = in_valid & in_ready;
    assign last_pix = accept && (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));
    assign lb_addr  = LB_AW'(col >> 1);
    assign lb_we    = accept & col[0] & ~row[0];
    assign emit     = accept & col[0] & row[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (state == IDLE && start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_comb begin
        pm     = DATA_W'(max_val(MAX_W'(pair_q), MAX_W'(in_data), DATA_W));
        pooled = DATA_W'(max_val(MAX_W'(lb_rdata), MAX_W'(pm), DATA_W));
`ifdef MAXPOOL_RELU_EN
        if (pooled[DATA_W-1]) begin
            pooled = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pair_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            out_valid <= emit;
            done      <= last_pix;
            if (accept && !col[0]) begin
                pair_q <= in_data;
            end
            if (emit) begin
                out_data <= pooled;
            end
        end
    end

    maxpool_linebuf #(
        .DATA_W (DATA_W),
        .DEPTH  (LB_DEPTH),
        .AW     (LB_AW)
    ) u_linebuf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (pm),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

endmodule

// File: tb/tb_conv_maxpool.sv
// Directed self-checking bench for conv_maxpool on a 4x4 map, 8-bit pixels.
// Expected values follow MAXPOOL_RELU_EN when it is defined for the build.
module tb_conv_maxpool;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] pix [16];
    logic [DW-1:0] exp4 [4];

    always #5 clk = ~clk;

    conv_maxpool #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // Runs one full frame; optional idle cycle before each pixel and an
    // optional start pulse coincident with pixel index start_at.
    task automatic run_frame(input logic [DW-1:0] p [16], input logic [DW-1:0] e [4],
                             input bit stall, input int start_at);
        int k = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("ready_after_start", in_ready, 1);
        for (int i = 0; i < 16; i++) begin
            if (stall) begin
                in_valid = 1'b0;
                in_data  = 8'hAA;
                tick();
                check("stall_no_out", out_valid, 0);
            end
            in_valid = 1'b1;
            in_data  = p[i];
            start    = (i == start_at);
            tick();
            in_valid = 1'b0;
            start    = 1'b0;
            if (((i / W) % 2 == 1) && ((i % W) % 2 == 1)) begin
                check("out_valid", out_valid, 1);
                check("out_data", out_data, e[k]);
                check("done", done, k == 3);
                k++;
            end else begin
                check("no_out", out_valid, 0);
                check("no_done", done, 0);
            end
        end
        check("out_count", k, 4);
        check("ready_drop", in_ready, 0);
        tick();
        check("valid_drop", out_valid, 0);
        check("done_drop", done, 0);
        check("data_hold", out_data, e[3]);
        check("still_idle", busy, 0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_data", out_data, 0);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Basic frame 0..15
        for (int i = 0; i < 16; i++) pix[i] = DW'(i);
        exp4[0] = 8'd5; exp4[1] = 8'd7; exp4[2] = 8'd13; exp4[3] = 8'd15;
        run_frame(pix, exp4, 1'b0, -1);

        // Same stream with a bubble before every pixel
        run_frame(pix, exp4, 1'b1, -1);

        // Max at TL of block 0, TR of block 1, BL of block 2, BR of block 3
        for (int i = 0; i < 16; i++) pix[i] = 8'd1;
        pix[0] = 8'd200; pix[3] = 8'd200; pix[12] = 8'd200; pix[15] = 8'd200;
`ifdef MAXPOOL_RELU_EN
        for (int i = 0; i < 4; i++) exp4[i] = 8'd1;
`else
        for (int i = 0; i < 4; i++) exp4[i] = 8'd200;
`endif
        run_frame(pix, exp4, 1'b0, -1);

        // Reset after 9 accepted pixels (pixel 7 has produced an output)
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_data", out_data, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_done", done, 0);
        check("abort_data", out_data, 0);
        check("abort_busy", busy, 0);
        tick();
        check("abort_no_done", done, 0);
        for (int i = 0; i < 16; i++) pix[i] = DW'(i);
        exp4[0] = 8'd5; exp4[1] = 8'd7; exp4[2] = 8'd13; exp4[3] = 8'd15;
        run_frame(pix, exp4, 1'b0, -1);

        // in_valid with 99 while idle must not be accepted
        in_valid = 1'b1;
        in_data  = 8'd99;
        tick();
        tick();
        check("idle_ready", in_ready, 0);
        check("idle_no_out", out_valid, 0);
        in_valid = 1'b0;
        // start mid-run (pixel 6) is ignored
        run_frame(pix, exp4, 1'b0, 6);
        // start with the final accept is ignored: block stays idle
        run_frame(pix, exp4, 1'b0, 15);
        tick();
        check("final_start_ignored", busy, 0);
        in_valid = 1'b1;
        in_data  = 8'd99;
        tick();
        in_valid = 1'b0;
        run_frame(pix, exp4, 1'b0, -1);

        // Signedness: block 0 = {-3,-1,-8,-2}, other blocks all 5
        for (int i = 0; i < 16; i++) pix[i] = 8'd5;
        pix[0] = 8'hFD; pix[1] = 8'hFF; pix[4] = 8'hF8; pix[5] = 8'hFE;
`ifdef MAXPOOL_RELU_EN
        exp4[0] = 8'h00;
`else
        exp4[0] = 8'hFF;
`endif
        exp4[1] = 8'd5; exp4[2] = 8'd5; exp4[3] = 8'd5;
        run_frame(pix, exp4, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
